// File: rtl/boron_round_sequencer.sv
// Iterative round controller for the Boron 64-bit block datapath: one block in,
// ROUNDS passes through the external round function, key whitening, one block out.
module boron_round_sequencer #(
  parameter int ROUNDS = 25,
  parameter int BLK_W  = 64,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             rk_req,
  output logic [IDX_W-1:0] rk_idx,
  input  logic             rk_valid,
  input  logic [BLK_W-1:0] rk_data,
  output logic [BLK_W-1:0] rf_state,
  output logic [BLK_W-1:0] rf_key,
  input  logic [BLK_W-1:0] rf_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic [IDX_W-1:0] round_cnt
);

  typedef enum logic [1:0] {IDLE, KEY, ROUND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

  state_t           state;
  logic [BLK_W-1:0] state_reg;
  logic [BLK_W-1:0] key_reg;
  logic [BLK_W-1:0] out_reg;

  // Handshake outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      out_reg   <= '0;
      round_cnt <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rk_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_data;
            round_cnt <= '0;
            state     <= KEY;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            rk_req    <= 1'b1;
          end
        end
        KEY: begin
          if (rk_valid) begin
            rk_req <= 1'b0;
            if (round_cnt == LAST_IDX) begin
              // Final whitening goes straight into the output register.
              out_reg   <= state_reg ^ rk_data;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              key_reg <= rk_data;
              state   <= ROUND;
            end
          end
        end
        ROUND: begin
          state_reg <= rf_result;
          round_cnt <= round_cnt + 1'b1;
          rk_req    <= 1'b1;
          state     <= KEY;
        end
        DONE: begin
          // in_ready rises only after the handoff edge, never on it.
          if (out_ready) begin
            round_cnt <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rk_idx   = round_cnt;
  assign rf_state = state_reg;
  assign rf_key   = key_reg;
  assign out_data = out_reg;

endmodule
